// File: rtl/wm_pkg.sv
// Shared state encoding, register map and CTRL bit positions for the watermark register bank.
// The WAIT state is only entered when APB_WAIT_STATE_EN is defined.
package wm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    WAIT   = 2'd3
  } apb_state_e;

  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_WHITE    = 1;
  localparam int ADDR_B_MAX    = 9;
  localparam int ADDR_PIX_BASE = 10;

  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_DONE  = 2;

endpackage

// File: rtl/apb_slave_fsm.sv
// APB3 protocol tracker: registered pready plus load (pre-pready) and commit strobes.
// APB_WAIT_STATE_EN inserts one pready=0 access cycle before completion.
module apb_slave_fsm
  import wm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic psel_i,
  input  logic penable_i,
  output logic pready_o,
  output logic load_o,
  output logic commit_o
);

  apb_state_e state_q;
  logic       pready_q;
  logic       go;

  assign go = psel_i & penable_i;

  // load_o marks the edge on which the completing cycle's pready/prdata/pslverr get registered
`ifdef APB_WAIT_STATE_EN
  assign load_o = (state_q == WAIT) & go;
`else
  assign load_o = (state_q == SETUP) & go;
`endif
  assign commit_o = (state_q == ACCESS) & pready_q;
  assign pready_o = pready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pready_q <= 1'b0;
    end else begin
      pready_q <= load_o;
      case (state_q)
        IDLE: begin
          if (psel_i && !penable_i) state_q <= SETUP;
        end
        SETUP: begin
          if (!psel_i) state_q <= IDLE;
`ifdef APB_WAIT_STATE_EN
          else if (penable_i) state_q <= WAIT;
`else
          else if (penable_i) state_q <= ACCESS;
`endif
        end
        WAIT: begin
`ifdef APB_WAIT_STATE_EN
          if (!psel_i) state_q <= IDLE;
          else if (penable_i) state_q <= ACCESS;
`else
          state_q <= IDLE;
`endif
        end
        ACCESS: begin
          state_q <= (psel_i && !penable_i) ? SETUP : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/apb_reg_bank.sv
// APB3 register bank for the watermark engine: CTRL/STATUS, config regs, pixel store, engine read port.
// Build with APB_WAIT_STATE_EN for one wait state per transfer.
module apb_reg_bank
  import wm_pkg::*;
#(
  parameter int Amba_Word       = 16,
  parameter int Amba_Addr_Depth = 20,
  parameter int Num_Regs        = 298,
  parameter int White_Default   = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [Amba_Addr_Depth:0] paddr,
  input  logic [Amba_Word-1:0]   pwdata,
  output logic [Amba_Word-1:0]   prdata,
  output logic                   pready,
  output logic                   pslverr,
  output logic                   start,
  input  logic                   done,
  input  logic [Amba_Addr_Depth:0] eng_addr,
  output logic [Amba_Word-1:0]   eng_rdata
);

  localparam int AW     = Amba_Addr_Depth + 1;
  localparam int PIX_N  = Num_Regs - ADDR_PIX_BASE;
  localparam int PIX_AW = (PIX_N > 1) ? $clog2(PIX_N) : 1;
  localparam logic [AW-1:0] LIMIT    = AW'(Num_Regs);
  localparam logic [AW-1:0] PIX_BASE = AW'(ADDR_PIX_BASE);
  localparam logic [AW-1:0] B_MIN    = AW'(ADDR_WHITE);
  localparam logic [AW-1:0] B_MAX    = AW'(ADDR_B_MAX);
  localparam logic [AW-1:0] CTRL_A   = AW'(ADDR_CTRL);

  logic [Amba_Word-1:0] cfg_q   [ADDR_WHITE:ADDR_B_MAX];
  logic [Amba_Word-1:0] pix_mem [PIX_N];
  logic [Amba_Word-1:0] prdata_q, eng_rdata_q;
  logic                 pslverr_q, start_q, start_d, sticky_q, sticky_d;
  logic                 load, commit, apb_err, wr_ok;

  apb_slave_fsm u_fsm (
    .clk      (clk),
    .rst      (rst),
    .psel_i   (psel),
    .penable_i(penable),
    .pready_o (pready),
    .load_o   (load),
    .commit_o (commit)
  );

  function automatic logic [PIX_AW-1:0] pix_idx(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - PIX_BASE;
    return off[PIX_AW-1:0];
  endfunction

  function automatic logic [Amba_Word-1:0] bank_read(input logic [AW-1:0] a);
    logic [Amba_Word-1:0] v;
    v = '0;
    if (a == CTRL_A) begin
      v[CTRL_START] = start_q;
      v[CTRL_BUSY]  = start_q;
      v[CTRL_DONE]  = sticky_q;
    end else if (a <= B_MAX) v = cfg_q[a[3:0]];
    else if (a < LIMIT) v = pix_mem[pix_idx(a)];
    return v;
  endfunction

  // Everything but CTRL is locked while the engine runs
  assign apb_err = (paddr >= LIMIT) | (pwrite & (paddr != CTRL_A) & start_q);
  assign wr_ok   = commit & pwrite & ~pslverr_q;

  // done pulse takes priority over a same-edge CTRL write
  always_comb begin
    start_d  = start_q;
    sticky_d = sticky_q;
    if (wr_ok && paddr == CTRL_A) begin
      start_d = pwdata[CTRL_START];
      if (pwdata[CTRL_DONE]) sticky_d = 1'b0;
    end
    if (done) begin
      start_d  = 1'b0;
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
      eng_rdata_q <= '0;
      start_q     <= 1'b0;
      sticky_q    <= 1'b0;
      for (int i = ADDR_WHITE; i <= ADDR_B_MAX; i++)
        cfg_q[i] <= (i == ADDR_WHITE) ? Amba_Word'(White_Default) : '0;
    end else begin
      start_q     <= start_d;
      sticky_q    <= sticky_d;
      eng_rdata_q <= bank_read(eng_addr);
      if (load) begin
        prdata_q  <= (apb_err || pwrite) ? '0 : bank_read(paddr);
        pslverr_q <= apb_err;
      end else begin
        prdata_q  <= '0;
        pslverr_q <= 1'b0;
      end
      if (wr_ok && paddr >= B_MIN && paddr <= B_MAX) cfg_q[paddr[3:0]] <= pwdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && paddr >= PIX_BASE && paddr < LIMIT) pix_mem[pix_idx(paddr)] <= pwdata;
  end

  assign prdata    = prdata_q;
  assign pslverr   = pslverr_q;
  assign start     = start_q;
  assign eng_rdata = eng_rdata_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed vector table plus hand sequences for engine port, run lock, done race, abort and reset.
module tb_apb_reg_bank;

  localparam int AW = 21;
`ifdef APB_WAIT_STATE_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 2;
`endif

  logic          clk = 1'b0, rst = 1'b0, psel = 1'b0, penable = 1'b0, pwrite = 1'b0, done = 1'b0;
  logic [AW-1:0] paddr = '0, eng_addr = '0;
  logic [15:0]   pwdata = '0;
  logic [15:0]   prdata, eng_rdata;
  logic          pready, pslverr, start;
  int            total = 0, bad = 0;

  always #5 clk = ~clk;

  apb_reg_bank dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .start(start), .done(done), .eng_addr(eng_addr),
    .eng_rdata(eng_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // One full transfer; optionally pulses done on the commit edge.
  task automatic apb(input bit wr, input logic [AW-1:0] a, input logic [15:0] d,
                     input bit done_at_commit, output logic [15:0] rd, output logic err,
                     output int lat);
    rd = '0; err = 1'b0; lat = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 2; c <= 8; c++) begin
      @(posedge clk); #1;
      if (pready) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL apb_timeout: got no pready want pready addr=0x%0h", a);
    end else begin
      rd = prdata; err = pslverr;
      if (done_at_commit) done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    $display("xfer %s addr=0x%0h wdata=0x%0h rdata=0x%0h err=%0b lat=%0d",
             wr ? "WR" : "RD", a, d, rd, err, lat);
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] a;
    logic [15:0]   d;
    logic [15:0]   exp;
    bit            exp_err;
  } vec_t;

  localparam int NV = 13;
  vec_t        vt[NV];
  logic [15:0] rd;
  logic        err;
  int          lat, seen;

  initial begin
    vt[0]  = '{1'b0, 21'd1,   16'h0,    16'd255,  1'b0};
    vt[1]  = '{1'b0, 21'd5,   16'h0,    16'h0,    1'b0};
    vt[2]  = '{1'b0, 21'd0,   16'h0,    16'h0,    1'b0};
    vt[3]  = '{1'b1, 21'd10,  16'h0080, 16'h0,    1'b0};
    vt[4]  = '{1'b0, 21'd10,  16'h0,    16'h0080, 1'b0};
    vt[5]  = '{1'b1, 21'd3,   16'h1234, 16'h0,    1'b0};
    vt[6]  = '{1'b0, 21'd3,   16'h0,    16'h1234, 1'b0};
    vt[7]  = '{1'b1, 21'd297, 16'hBEEF, 16'h0,    1'b0};
    vt[8]  = '{1'b0, 21'd297, 16'h0,    16'hBEEF, 1'b0};
    vt[9]  = '{1'b0, 21'd298, 16'h0,    16'h0,    1'b1};
    vt[10] = '{1'b1, 21'd298, 16'hFFFF, 16'h0,    1'b1};
    vt[11] = '{1'b1, 21'd9,   16'hA5A5, 16'h0,    1'b0};
    vt[12] = '{1'b0, 21'd9,   16'h0,    16'hA5A5, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", pready, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_start", start, 0);
    chk("rst_eng", eng_rdata, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_pslverr", pslverr, 0);

    for (int i = 0; i < NV; i++) begin
      apb(vt[i].wr, vt[i].a, vt[i].d, 1'b0, rd, err, lat);
      chk($sformatf("vec%0d_err", i), err, vt[i].exp_err);
      if (!vt[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, EXP_LAT);
    end

    eng_addr = 21'd10;  @(posedge clk); #1; chk("eng_pix", eng_rdata, 16'h0080);
    eng_addr = 21'd298; @(posedge clk); #1; chk("eng_oor", eng_rdata, 16'h0);
    eng_addr = 21'd1;   @(posedge clk); #1; chk("eng_white", eng_rdata, 16'd255);
    apb(1'b1, 21'd11, 16'h2222, 1'b0, rd, err, lat);
    eng_addr = 21'd11;
    apb(1'b1, 21'd11, 16'h1111, 1'b0, rd, err, lat);
    chk("eng_same_edge_old", eng_rdata, 16'h2222);
    @(posedge clk); #1;
    chk("eng_new", eng_rdata, 16'h1111);

    apb(1'b1, 21'd0, 16'h0001, 1'b0, rd, err, lat);
    chk("run_start", start, 1);
    apb(1'b0, 21'd0, 16'h0, 1'b0, rd, err, lat);
    chk("run_ctrl", rd, 16'h3);
    apb(1'b1, 21'd2, 16'd12, 1'b0, rd, err, lat);
    chk("lock_err", err, 1);
    apb(1'b0, 21'd2, 16'h0, 1'b0, rd, err, lat);
    chk("lock_unchanged", rd, 16'h0);
    apb(1'b1, 21'd0, 16'h0001, 1'b0, rd, err, lat);
    chk("restart_noerr", err, 0);
    chk("restart_start", start, 1);
    @(posedge clk); #1; done = 1'b1;
    @(posedge clk); #1; done = 1'b0;
    chk("done_start", start, 0);
    apb(1'b0, 21'd0, 16'h0, 1'b0, rd, err, lat);
    chk("done_ctrl", rd, 16'h4);
    apb(1'b1, 21'd0, 16'h0004, 1'b0, rd, err, lat);
    apb(1'b0, 21'd0, 16'h0, 1'b0, rd, err, lat);
    chk("sticky_clear", rd, 16'h0);

    apb(1'b1, 21'd0, 16'h0001, 1'b0, rd, err, lat);
    apb(1'b1, 21'd0, 16'h0001, 1'b1, rd, err, lat);
    chk("race_start", start, 0);
    apb(1'b0, 21'd0, 16'h0, 1'b0, rd, err, lat);
    chk("race_ctrl", rd, 16'h4);

    // psel dropped after setup
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 21'd3; pwdata = 16'h0055;
    @(posedge clk); #1;
    psel = 1'b0; pwrite = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (pready) seen = 1;
    end
    chk("abort_no_pready", seen, 0);
    apb(1'b0, 21'd3, 16'h0, 1'b0, rd, err, lat);
    chk("abort_unchanged", rd, 16'h1234);

    // penable without setup is ignored
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 21'd3; pwdata = 16'h0066;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (pready) seen = 1;
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("noset_no_pready", seen, 0);
    apb(1'b0, 21'd3, 16'h0, 1'b0, rd, err, lat);
    chk("noset_unchanged", rd, 16'h1234);

    // reset during the completing cycle drops the write
    apb(1'b1, 21'd12, 16'h3333, 1'b0, rd, err, lat);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 21'd12; pwdata = 16'h4444;
    @(posedge clk); #1;
    penable = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (pready) begin
        seen = 1;
        break;
      end
    end
    chk("midrst_pready", seen, 1);
    rst = 1'b0;
    #2;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    apb(1'b0, 21'd12, 16'h0, 1'b0, rd, err, lat);
    chk("midrst_pixel", rd, 16'h3333);
    apb(1'b0, 21'd1, 16'h0, 1'b0, rd, err, lat);
    chk("midrst_white", rd, 16'd255);
    chk("midrst_start", start, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
